// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (I) and load/store (D),
// D-priority with a starvation counter, one outstanding transaction, misalignment trapping.
module mem_port_arbiter #(
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_req,
   input  logic [XLEN-1:0] i_addr,
   output logic            i_gnt,
   output logic            i_rvalid,
   output logic [XLEN-1:0] i_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [1:0]      d_size,
   input  logic [XLEN-1:0] d_addr,
   input  logic [XLEN-1:0] d_wdata,
   output logic            d_gnt,
   output logic            d_rvalid,
   output logic [XLEN-1:0] d_rdata,
   output logic            d_err,
   output logic            m_req,
   output logic            m_we,
   output logic [XLEN-1:0] m_addr,
   output logic [3:0]      m_be,
   output logic [XLEN-1:0] m_wdata,
   input  logic            m_ready,
   input  logic            m_rvalid,
   input  logic [XLEN-1:0] m_rdata
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_t;
   state_t          state_q, state_d;
   logic            own_d_q, own_d_d;
   logic            err_ack_q, err_ack_d;
   logic [3:0]      starve_q, starve_d;
   logic            m_we_q, m_we_d;
   logic [XLEN-1:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
   logic [3:0]      m_be_q, m_be_d;
   logic            i_win, d_win, d_mis;
   logic [3:0]      d_be;
   logic [XLEN-1:0] d_lane;
   assign i_win  = i_req && starve_q == 4'(STARVE_LIMIT);
   assign d_win  = d_req && !i_win;
   assign d_mis  = d_size == 2'b11 || (d_size == 2'b01 && d_addr[0]) || (d_size == 2'b10 && d_addr[1:0] != 2'b00);
   assign d_be   = d_size == 2'b00 ? 4'b0001 << d_addr[1:0] : d_size == 2'b01 ? 4'b0011 << d_addr[1:0] : 4'b1111;
   assign d_lane = d_size == 2'b00 ? XLEN'({4{d_wdata[7:0]}}) : d_size == 2'b01 ? XLEN'({2{d_wdata[15:0]}}) : d_wdata;
   assign m_req    = state_q == ISSUE;
   assign i_gnt    = m_req && !own_d_q && m_ready;
   assign d_gnt    = (m_req && own_d_q && m_ready) || (state_q == ERR && !err_ack_q);
   assign i_rvalid = state_q == WAIT && !own_d_q && m_rvalid;
   assign d_err    = state_q == ERR && err_ack_q;
   assign d_rvalid = (state_q == WAIT && own_d_q && m_rvalid) || d_err;
   // Read data is only driven while its rvalid is high so idle outputs stay 0.
   assign i_rdata  = i_rvalid ? m_rdata : '0;
   assign d_rdata  = d_rvalid && !d_err ? m_rdata : '0;
   assign m_we     = m_we_q;
   assign m_addr   = m_addr_q;
   assign m_be     = m_be_q;
   assign m_wdata  = m_wdata_q;
   always_comb begin
      state_d   = state_q;
      own_d_d   = own_d_q;
      err_ack_d = 1'b0;
      m_we_d    = m_we_q;
      m_addr_d  = m_addr_q;
      m_be_d    = m_be_q;
      m_wdata_d = m_wdata_q;
      starve_d  = i_gnt ? 4'd0 : d_gnt && i_req && starve_q != 4'(STARVE_LIMIT) ? starve_q + 4'd1 : starve_q;
      case (state_q)
         IDLE: begin
            if (d_win) begin
               own_d_d   = 1'b1;
               m_we_d    = d_we;
               m_addr_d  = {d_addr[XLEN-1:2], 2'b00};
               m_be_d    = d_be;
               m_wdata_d = d_lane;
               state_d   = d_mis ? ERR : ISSUE;
            end else if (i_req) begin
               own_d_d   = 1'b0;
               m_we_d    = 1'b0;
               m_addr_d  = {i_addr[XLEN-1:2], 2'b00};
               m_be_d    = 4'b1111;
               m_wdata_d = '0;
               state_d   = ISSUE;
            end
         end
         ISSUE: state_d = m_ready ? WAIT : ISSUE;
         WAIT:  state_d = m_rvalid ? IDLE : WAIT;
         ERR: begin
            err_ack_d = !err_ack_q;
            state_d   = err_ack_q ? IDLE : ERR;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         own_d_q   <= 1'b0;
         err_ack_q <= 1'b0;
         starve_q  <= 4'd0;
         m_we_q    <= 1'b0;
         m_addr_q  <= '0;
         m_be_q    <= 4'b0;
         m_wdata_q <= '0;
      end else begin
         state_q   <= state_d;
         own_d_q   <= own_d_d;
         err_ack_q <= err_ack_d;
         starve_q  <= starve_d;
         m_we_q    <= m_we_d;
         m_addr_q  <= m_addr_d;
         m_be_q    <= m_be_d;
         m_wdata_q <= m_wdata_d;
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand sequences for contention,
// reset mid-transaction and reset state.
module tb_mem_port_arbiter;
   logic        clk = 0, rst = 1;
   logic        i_req = 0, d_req = 0, d_we = 0, m_ready = 0, m_rvalid = 0;
   logic [1:0]  d_size = 0;
   logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
   logic        i_gnt, i_rvalid, d_gnt, d_rvalid, d_err, m_req, m_we;
   logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
   logic [3:0]  m_be;
   int checks = 0, failures = 0;

   mem_port_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
      .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        is_d, we, mis;
      logic [1:0]  size;
      logic [31:0] addr, wdata, rdata;
      int          bp;
      logic [31:0] e_addr, e_wdata;
      logic [3:0]  e_be;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string name);
      chk(name, {31'd0, |{i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
                         m_req, m_we, m_addr, m_be, m_wdata}}, 32'd0);
   endtask

   task automatic idle_inputs();
      i_req = 0; d_req = 0; d_we = 0; d_size = 0; i_addr = 0; d_addr = 0;
      d_wdata = 0; m_ready = 0; m_rvalid = 0; m_rdata = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      idle_inputs();
      #1 chk_zero("reset_outputs");
      @(negedge clk);
      rst = 0;
   endtask

   task automatic txn(input vec_t v);
      @(negedge clk);
      i_req = !v.is_d; i_addr = v.addr;
      d_req = v.is_d; d_we = v.we; d_size = v.size; d_addr = v.addr; d_wdata = v.wdata;
      m_ready = 0; m_rvalid = 0;
      @(posedge clk); #1;
      if (v.mis) begin
         chk("err_mreq", m_req, 0);
         chk("err_gnt", d_gnt, 1);
         chk("err_rvalid_early", d_rvalid, 0);
         d_req = 0;
         @(posedge clk); #1;
         chk("err_gnt_once", d_gnt, 0);
         chk("err_rvalid", d_rvalid, 1);
         chk("err_flag", d_err, 1);
         chk("err_rdata", d_rdata, 0);
         chk("err_mreq2", m_req, 0);
      end else begin
         for (int k = 0; k <= v.bp; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            m_ready = (k == v.bp);
            #1;
            chk("m_req", m_req, 1);
            chk("m_addr", m_addr, v.e_addr);
            chk("m_be", {28'd0, m_be}, {28'd0, v.e_be});
            chk("m_we", m_we, v.is_d & v.we);
            if (v.is_d) chk("m_wdata", m_wdata, v.e_wdata);
            chk("gnt", v.is_d ? d_gnt : i_gnt, k == v.bp);
            chk("other_gnt", v.is_d ? i_gnt : d_gnt, 0);
         end
         @(posedge clk); #1;
         i_req = 0; d_req = 0; m_ready = 0;
         chk("wait_mreq", m_req, 0);
         chk("wait_no_gnt", {31'd0, i_gnt | d_gnt}, 0);
         m_rvalid = 1; m_rdata = v.rdata;
         #1;
         chk("rvalid", v.is_d ? d_rvalid : i_rvalid, 1);
         chk("other_rvalid", v.is_d ? i_rvalid : d_rvalid, 0);
         chk("rdata", v.is_d ? d_rdata : i_rdata, v.rdata);
         chk("other_rdata", v.is_d ? i_rdata : d_rdata, 0);
         chk("d_err", d_err, 0);
      end
      @(posedge clk); #1;
      m_rvalid = 0; i_req = 0; d_req = 0;
   endtask

   initial begin
      //          is_d we mis size   addr           wdata          rdata          bp e_addr         e_wdata        e_be
      vecs[0] = '{0, 0, 0, 2'b10, 32'h0000_0100, 32'h0,         32'h0050_0093, 0, 32'h0000_0100, 32'h0,         4'b1111};
      vecs[1] = '{1, 1, 0, 2'b00, 32'h0000_0203, 32'h0000_00AB, 32'h1111_2222, 0, 32'h0000_0200, 32'hABAB_ABAB, 4'b1000};
      vecs[2] = '{1, 1, 0, 2'b01, 32'h0000_0202, 32'h1234_CDEF, 32'h0,         0, 32'h0000_0200, 32'hCDEF_CDEF, 4'b1100};
      vecs[3] = '{1, 1, 0, 2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         0, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111};
      vecs[4] = '{1, 0, 0, 2'b00, 32'h0000_0001, 32'h0000_0055, 32'hCAFE_F00D, 0, 32'h0000_0000, 32'h5555_5555, 4'b0010};
      vecs[5] = '{1, 0, 1, 2'b10, 32'h0000_1002, 32'h0,         32'h0,         0, 32'h0,         32'h0,         4'b0000};
      vecs[6] = '{1, 1, 1, 2'b01, 32'h0000_1001, 32'h0,         32'h0,         0, 32'h0,         32'h0,         4'b0000};
      vecs[7] = '{1, 0, 1, 2'b11, 32'h0000_0000, 32'h0,         32'h0,         0, 32'h0,         32'h0,         4'b0000};
      vecs[8] = '{1, 0, 0, 2'b01, 32'h0000_0402, 32'h0,         32'h8765_4321, 3, 32'h0000_0400, 32'h0,         4'b1100};
      vecs[9] = '{0, 0, 0, 2'b10, 32'h0000_0204, 32'h0,         32'h0BAD_C0DE, 1, 32'h0000_0204, 32'h0,         4'b1111};

      do_reset();
      foreach (vecs[i]) txn(vecs[i]);

      // Contention: both requesters held high, expect D x4 then I, twice.
      begin
         logic exp_d [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
         logic got_d [10];
         int n = 0;
         do_reset();
         @(negedge clk);
         i_req = 1; i_addr = 32'h80; d_req = 1; d_we = 0; d_size = 2'b10; d_addr = 32'h40;
         m_ready = 1; m_rvalid = 1;
         for (int c = 0; c < 100 && n < 10; c++) begin
            @(posedge clk); #1;
            if (i_gnt && d_gnt) chk("both_gnt", 1, 0);
            if (i_gnt || d_gnt) begin
               got_d[n] = d_gnt;
               n++;
            end
         end
         chk("contention_grants", n, 10);
         for (int j = 0; j < n; j++) chk($sformatf("grant_%0d_is_d", j), {31'd0, got_d[j]}, {31'd0, exp_d[j]});
         idle_inputs();
      end

      // Reset while waiting for the response abandons the transaction.
      do_reset();
      @(negedge clk);
      i_req = 1; i_addr = 32'h300; m_ready = 1;
      @(posedge clk); #1;
      chk("rst_seq_gnt", i_gnt, 1);
      @(posedge clk); #1;
      i_req = 0; m_ready = 0;
      rst = 1;
      #1 chk_zero("async_reset_outputs");
      @(negedge clk);
      rst = 0; m_rvalid = 1; m_rdata = 32'h1234_5678;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         chk("stale_rvalid", {31'd0, i_rvalid | d_rvalid}, 0);
         chk_zero("post_reset_outputs");
      end
      m_rvalid = 0;
      txn('{0, 0, 0, 2'b10, 32'h0000_0300, 32'h0, 32'h600D_F00D, 0, 32'h0000_0300, 32'h0, 4'b1111});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
